// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial sequencer for a 1-bit ALU: streams WIDTH-bit operands LSB-first and rebuilds the carry chain.
// Optional flags (out_carry/out_zero) are enabled by defining BSALU_FLAGS_EN.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [2:0]       alu_s,
  output logic             alu_a,
  output logic             alu_b,
  input  logic             alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BSALU_FLAGS_EN
  ,
  output logic             out_carry,
  output logic             out_zero
`endif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             a_bit, b_bit, res_bit, c_nxt;
`ifdef BSALU_FLAGS_EN
  logic             carry_q, carry_d, zero_q, zero_d;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    alu_s    = 3'b111;
    alu_a    = 1'b0;
    alu_b    = 1'b0;
    a_bit    = opa_q[cnt_q];
    // inc/dec/inv/identity (op[1] set) never use operand B
    b_bit    = op_q[1] ? 1'b0 : opb_q[cnt_q];
    res_bit  = 1'b0;
    c_nxt    = 1'b0;
    in_ready = (state_q == IDLE);
    out_valid = (state_q == DONE);
`ifdef BSALU_FLAGS_EN
    carry_d  = carry_q;
    zero_d   = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op;
          opa_d   = opa;
          opb_d   = opb;
          cnt_d   = '0;
          c_d     = (op == 3'b010) || (op == 3'b011);
          state_d = RUN;
        end
      end
      RUN: begin
        alu_a = a_bit;
        alu_b = b_bit;
        alu_s = (op_q == 3'b010) ? 3'b000 : (op_q == 3'b011) ? 3'b001 : op_q;
        if (!op_q[2]) begin
          // ALU returns a^b; fold in the carry/borrow it does not track
          res_bit = alu_result ^ c_q;
          c_nxt   = op_q[0] ? ((~a_bit & b_bit) | (c_q & ~(a_bit ^ b_bit)))
                            : ((a_bit & b_bit) | (c_q & (a_bit ^ b_bit)));
        end else begin
          res_bit = alu_result;
          c_nxt   = 1'b0;
        end
        res_d = {res_bit, res_q[WIDTH-1:1]};
        c_d   = c_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
`ifdef BSALU_FLAGS_EN
          carry_d = c_nxt;
          zero_d  = (res_d == '0);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
`ifdef BSALU_FLAGS_EN
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
`ifdef BSALU_FLAGS_EN
      carry_q <= carry_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign out_data = res_q;
`ifdef BSALU_FLAGS_EN
  assign out_carry = carry_q;
  assign out_zero  = zero_q;
`endif

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed bench for bit_serial_alu_ctrl (WIDTH=8) with a behavioural 1-bit ALU.
module tb_bit_serial_alu_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   op, alu_s;
  logic [W-1:0] opa, opb, out_data;
  logic         alu_a, alu_b, alu_result;
`ifdef BSALU_FLAGS_EN
  logic         out_carry, out_zero;
`endif

  int n_tot = 0;
  int n_bad = 0;

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .opa(opa), .opb(opb),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef BSALU_FLAGS_EN
    , .out_carry(out_carry), .out_zero(out_zero)
`endif
  );

  always #5 clk = ~clk;

  // plain 1-bit ALU: add/sub give a^b only, no carry
  always_comb begin
    case (alu_s)
      3'b000, 3'b001: alu_result = alu_a ^ alu_b;
      3'b100:         alu_result = alu_a & alu_b;
      3'b101:         alu_result = alu_a | alu_b;
      3'b110:         alu_result = ~alu_a;
      3'b111:         alu_result = alu_a;
      default:        alu_result = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] r;
  logic         cy, zr;
  int           lat;

  // issue one op, wait for result, handshake it; lat counts cycles after the accept cycle
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    @(negedge clk);
    in_valid = 1'b1; op = o; opa = a; opb = b;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    r  = out_data;
`ifdef BSALU_FLAGS_EN
    cy = out_carry; zr = out_zero;
`else
    cy = 1'b0; zr = 1'b0;
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [2:0]   bop [3];
  logic [W-1:0] ba  [3];
  logic [W-1:0] bb  [3];
  logic [W-1:0] bexp[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, got, cyc, last;
    logic acc, ovld;
    logic [W-1:0] odat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_s", alu_s, 3'b111);

    // arithmetic
    do_op(3'b000, 8'hFF, 8'h01);
    chk("add_data", r, 8'h00); chk("add_latency", lat, 9);
`ifdef BSALU_FLAGS_EN
    chk("add_carry", cy, 1); chk("add_zero", zr, 1);
`endif
    chk("post_hs_out_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
    do_op(3'b001, 8'h05, 8'h07);
    chk("sub_data", r, 8'hFE);
`ifdef BSALU_FLAGS_EN
    chk("sub_borrow", cy, 1); chk("sub_zero", zr, 0);
`endif
    do_op(3'b011, 8'h00, 8'h55);
    chk("dec_data", r, 8'hFF);
`ifdef BSALU_FLAGS_EN
    chk("dec_borrow", cy, 1);
`endif
    do_op(3'b010, 8'h7F, 8'hFF);
    chk("inc_data", r, 8'h80);
`ifdef BSALU_FLAGS_EN
    chk("inc_carry", cy, 0);
`endif

    // logic ops
    do_op(3'b100, 8'hF0, 8'h3C); chk("and_data", r, 8'h30);
`ifdef BSALU_FLAGS_EN
    chk("and_carry", cy, 0);
`endif
    do_op(3'b101, 8'hF0, 8'h0C); chk("or_data", r, 8'hFC);
`ifdef BSALU_FLAGS_EN
    chk("or_carry", cy, 0);
`endif
    do_op(3'b110, 8'hA5, 8'hFF); chk("inv_data", r, 8'h5A);
`ifdef BSALU_FLAGS_EN
    chk("inv_carry", cy, 0);
`endif
    do_op(3'b111, 8'h3C, 8'hFF); chk("id_data", r, 8'h3C);
`ifdef BSALU_FLAGS_EN
    chk("id_carry", cy, 0);
`endif

    // stall in DONE, in_valid pulses during RUN ignored; dec 0x10 -> 0x0F
    @(negedge clk);
    chk("stall_idle", in_ready, 1);
    in_valid = 1'b1; op = 3'b011; opa = 8'h10; opb = 8'hAA;
    @(negedge clk);
    op = 3'b000; opa = 8'hFF; opb = 8'hFF;
    chk("run_in_ready", in_ready, 0);
    chk("run_alu_s_dec", alu_s, 3'b001);
    chk("run_alu_b_dec", alu_b, 0);
    chk("run_alu_a_bit0", alu_a, 0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 30) begin @(negedge clk); k++; end
    chk("stall_reach_done", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 8'h0F);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_release", out_valid, 0);
    repeat (3) @(negedge clk);
    chk("no_ghost_op", in_ready, 1);

    // reset during RUN cycle 4
    in_valid = 1'b1; op = 3'b000; opa = 8'h11; opb = 8'h22;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    do_op(3'b000, 8'h02, 8'h03);
    chk("after_abort_add", r, 8'h05);

    // back-to-back with in_valid and out_ready held high
    bop[0] = 3'b000; ba[0] = 8'h10; bb[0] = 8'h20; bexp[0] = 8'h30;
    bop[1] = 3'b001; ba[1] = 8'h50; bb[1] = 8'h08; bexp[1] = 8'h48;
    bop[2] = 3'b101; ba[2] = 8'h01; bb[2] = 8'h02; bexp[2] = 8'h03;
    k = 0; got = 0; cyc = 0; last = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (got < 3 && cyc < 200) begin
      if (k < 3) begin
        in_valid = 1'b1; op = bop[k]; opa = ba[k]; opb = bb[k];
      end else in_valid = 1'b0;
      acc  = in_valid && in_ready;
      ovld = out_valid;
      odat = out_data;
      if (ovld) begin
        chk("b2b_data", odat, bexp[got]);
        if (got > 0) chk("b2b_interval", cyc - last, 10);
        chk("b2b_excl", in_ready, 0);
        last = cyc;
        got++;
      end
      @(posedge clk);
      if (acc) k++;
      @(negedge clk);
      cyc++;
    end
    chk("b2b_count", got, 3);
    out_ready = 1'b0; in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
